// File: rtl/alu_seq_if.sv
// -----------------------------------------------------------------------------
// alu_seq_if
// Handshake bundle between an operand-issuing controller and alu_seq, plus the
// result side towards the consumer.
//
// Signals:
//   in_valid   controller -> alu   operands and op valid this cycle
//   in_ready   alu -> controller   alu accepts operands this cycle
//   a, b       controller -> alu   operands, WIDTH bits
//   op         controller -> alu   operation select, 3 bits
//   out_valid  alu -> consumer     result registers hold a valid result
//   out_ready  consumer -> alu     consumer takes the result this cycle
//   result     alu -> consumer     registered result, WIDTH bits
//   carry      alu -> consumer     registered carry/borrow/overflow flag
//   zero       alu -> consumer     registered result == 0 flag
//
// Modports:
//   master  controller/consumer side (drives operands and out_ready)
//   slave   alu_seq side
// -----------------------------------------------------------------------------
interface alu_seq_if #(
   parameter int WIDTH = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [2:0]       op;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] result;
   logic             carry;
   logic             zero;

   modport master (
      output in_valid, a, b, op, out_ready,
      input  in_ready, out_valid, result, carry, zero
   );

   modport slave (
      input  in_valid, a, b, op, out_ready,
      output in_ready, out_valid, result, carry, zero
   );
endinterface

// File: rtl/alu_seq.sv
// -----------------------------------------------------------------------------
// alu_seq
// Handshaked ALU with registered result. Single-cycle ops (ADD, SUB, AND, OR,
// XOR, NOT, and SLT/div-by-zero) present their result the cycle after accept;
// MUL (and DIV when enabled) iterate one bit per cycle for WIDTH cycles while
// new input is held off.
//
// Build option:
//   ALU_DIV_EN  defined   -> op 110 is an unsigned restoring divide
//               undefined -> op 110 is unsigned set-less-than, no divider
//
// Parameters:
//   WIDTH   operand/result width, 2..32
//
// Ports:
//   clk     rising-edge clock
//   rst_n   asynchronous active-low reset
//   bus     alu_seq_if.slave: in_valid/in_ready/a/b/op on the issue side,
//           out_valid/out_ready/result/carry/zero on the result side
// -----------------------------------------------------------------------------
module alu_seq #(
   parameter int WIDTH = 8
) (
   input  logic     clk,
   input  logic     rst_n,
   alu_seq_if.slave bus
);

   localparam int CNT_W = $clog2(WIDTH + 1);

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;
   localparam logic [2:0] OP_XOR = 3'b100;
   localparam logic [2:0] OP_MUL = 3'b101;
   localparam logic [2:0] OP_D6  = 3'b110;
   localparam logic [2:0] OP_NOT = 3'b111;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   // State and datapath registers
   state_t             state_q;
   logic [CNT_W-1:0]   cnt_q;
   logic [WIDTH-1:0]   opa_q;
   // MUL: {partial product high, multiplier/product low}
   // DIV: {remainder, dividend/quotient}
   logic [2*WIDTH-1:0] prod_q;
   logic [WIDTH-1:0]   result_q;
   logic               carry_q;
   logic               zero_q;
`ifdef ALU_DIV_EN
   logic [WIDTH-1:0]   opb_q;
   logic               is_div_q;
`endif

   // Combinational helpers
   logic               accept;
   logic               last_iter;
   logic [WIDTH:0]     add_sum;
   logic [WIDTH:0]     sub_diff;
   logic [WIDTH-1:0]   sc_result_d;
   logic               sc_carry_d;
   logic               sc_zero_d;
   logic               start_iter;
   logic [WIDTH:0]     mul_sum;
   logic [2*WIDTH-1:0] mul_next;
   logic [2*WIDTH-1:0] prod_d;
   logic [WIDTH-1:0]   fin_result_d;
   logic               fin_carry_d;
   logic               fin_zero_d;

   // in_ready looks at out_ready combinationally so a stalled result can be
   // replaced in the same cycle it is consumed.
   assign bus.in_ready  = (state_q == IDLE) || ((state_q == DONE) && bus.out_ready);
   assign bus.out_valid = (state_q == DONE);
   assign bus.result    = result_q;
   assign bus.carry     = carry_q;
   assign bus.zero      = zero_q;

   assign accept    = bus.in_valid && bus.in_ready;
   assign last_iter = (cnt_q == CNT_W'(1));

   assign add_sum  = {1'b0, bus.a} + {1'b0, bus.b};
   // Top bit of the extended difference is the borrow (a < b).
   assign sub_diff = {1'b0, bus.a} - {1'b0, bus.b};

   // Single-cycle result from the live inputs, registered on accept.
   always_comb begin
      sc_result_d = '0;
      sc_carry_d  = 1'b0;
      start_iter  = 1'b0;
      case (bus.op)
         OP_ADD: {sc_carry_d, sc_result_d} = add_sum;
         OP_SUB: begin
            sc_result_d = sub_diff[WIDTH-1:0];
            sc_carry_d  = sub_diff[WIDTH];
         end
         OP_AND: sc_result_d = bus.a & bus.b;
         OP_OR:  sc_result_d = bus.a | bus.b;
         OP_XOR: sc_result_d = bus.a ^ bus.b;
         OP_MUL: start_iter  = 1'b1;
`ifdef ALU_DIV_EN
         OP_D6: begin
            // Divide by zero short-circuits: all ones with carry, no BUSY.
            if (bus.b == '0) begin
               sc_result_d = '1;
               sc_carry_d  = 1'b1;
            end else begin
               start_iter  = 1'b1;
            end
         end
`else
         OP_D6:  sc_result_d = {{(WIDTH-1){1'b0}}, (bus.a < bus.b)};
`endif
         OP_NOT: sc_result_d = ~bus.a;
         default: sc_result_d = '0;
      endcase
   end

   assign sc_zero_d = (sc_result_d == '0);

   // Shift-add multiply step: add the multiplicand to the high half when the
   // current multiplier LSB is set, then shift the whole product right. The
   // sum's carry-out becomes the new MSB.
   assign mul_sum  = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, opa_q} : '0);
   assign mul_next = {mul_sum, prod_q[WIDTH-1:1]};

`ifdef ALU_DIV_EN
   logic [WIDTH:0]     div_shift;
   logic [WIDTH:0]     div_trial;
   logic [2*WIDTH-1:0] div_next;

   // Restoring divide step: shift the next dividend bit into the remainder,
   // trial-subtract the divisor, keep the difference if it did not borrow.
   // The remainder is always below the divisor, so the kept value fits WIDTH.
   assign div_shift = prod_q[2*WIDTH-1:WIDTH-1];
   assign div_trial = div_shift - {1'b0, opb_q};
   assign div_next  = {(div_trial[WIDTH] ? div_shift[WIDTH-1:0] : div_trial[WIDTH-1:0]),
                       prod_q[WIDTH-2:0], ~div_trial[WIDTH]};

   assign prod_d      = is_div_q ? div_next : mul_next;
   assign fin_carry_d = !is_div_q && (|prod_d[2*WIDTH-1:WIDTH]);
`else
   assign prod_d      = mul_next;
   assign fin_carry_d = |prod_d[2*WIDTH-1:WIDTH];
`endif

   assign fin_result_d = prod_d[WIDTH-1:0];
   assign fin_zero_d   = (fin_result_d == '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         opa_q    <= '0;
         prod_q   <= '0;
         result_q <= '0;
         carry_q  <= 1'b0;
         zero_q   <= 1'b0;
`ifdef ALU_DIV_EN
         opb_q    <= '0;
         is_div_q <= 1'b0;
`endif
      end else begin
         case (state_q)
            IDLE, DONE: begin
               if (accept) begin
                  opa_q <= bus.a;
                  if (start_iter) begin
                     state_q <= BUSY;
                     cnt_q   <= CNT_W'(WIDTH);
`ifdef ALU_DIV_EN
                     opb_q    <= bus.b;
                     is_div_q <= (bus.op == OP_D6);
                     // Divide starts from the dividend, multiply from the multiplier.
                     prod_q   <= {{WIDTH{1'b0}}, ((bus.op == OP_D6) ? bus.a : bus.b)};
`else
                     prod_q   <= {{WIDTH{1'b0}}, bus.b};
`endif
                  end else begin
                     state_q  <= DONE;
                     result_q <= sc_result_d;
                     carry_q  <= sc_carry_d;
                     zero_q   <= sc_zero_d;
                  end
               end else if ((state_q == DONE) && bus.out_ready) begin
                  state_q <= IDLE;
               end
            end

            BUSY: begin
               prod_q <= prod_d;
               cnt_q  <= cnt_q - CNT_W'(1);
               if (last_iter) begin
                  state_q  <= DONE;
                  result_q <= fin_result_d;
                  carry_q  <= fin_carry_d;
                  zero_q   <= fin_zero_d;
               end
            end

            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_seq.sv
module tb_alu_seq;

   localparam int WIDTH = 8;

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;
   localparam logic [2:0] OP_XOR = 3'b100;
   localparam logic [2:0] OP_MUL = 3'b101;
   localparam logic [2:0] OP_D6  = 3'b110;
   localparam logic [2:0] OP_NOT = 3'b111;

   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   alu_seq_if #(.WIDTH(WIDTH)) bus ();

   alu_seq #(.WIDTH(WIDTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int n_chk = 0;
   int n_bad = 0;

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic [2:0] op;
      logic [7:0] r;
      logic       c;
      logic       z;
      int         lat;   // clock edges from the accept edge until out_valid
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present one operation, wait for it to be accepted, then wait (bounded)
   // for out_valid. Records whether in_ready was ever seen high while waiting.
   task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_v, input logic [2:0] top,
                         output int lat, output logic rdy_seen);
      int n;
      bus.a        = ta;
      bus.b        = tb_v;
      bus.op       = top;
      bus.in_valid = 1'b1;
      n = 0;
      while (!bus.in_ready && n < 50) begin
         step();
         n++;
      end
      step();
      bus.in_valid = 1'b0;
      lat      = 0;
      rdy_seen = 1'b0;
      while (!bus.out_valid && lat < 40) begin
         rdy_seen = rdy_seen | bus.in_ready;
         step();
         lat++;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int   lat;
      logic rdy_seen;
      logic seen;

      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      bus.a         = '0;
      bus.b         = '0;
      bus.op        = '0;
      rst_n         = 1'b1;
      #1 rst_n      = 1'b0;
      #11;
      chk("rst_in_ready",  bus.in_ready,  1);
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_result",    bus.result,    0);
      chk("rst_carry",     bus.carry,     0);
      chk("rst_zero",      bus.zero,      0);
      rst_n = 1'b1;
      step();

      vecs.push_back('{8'd4,   8'd2,   OP_ADD, 8'd6,   1'b0, 1'b0, 0});
      vecs.push_back('{8'd4,   8'd2,   OP_SUB, 8'd2,   1'b0, 1'b0, 0});
      vecs.push_back('{8'd4,   8'd2,   OP_AND, 8'd0,   1'b0, 1'b1, 0});
      vecs.push_back('{8'd4,   8'd2,   OP_OR,  8'd6,   1'b0, 1'b0, 0});
      vecs.push_back('{8'd4,   8'd2,   OP_XOR, 8'd6,   1'b0, 1'b0, 0});
      vecs.push_back('{8'd4,   8'd2,   OP_NOT, 8'd251, 1'b0, 1'b0, 0});
      vecs.push_back('{8'd2,   8'd4,   OP_SUB, 8'd254, 1'b1, 1'b0, 0});
      vecs.push_back('{8'd200, 8'd100, OP_ADD, 8'd44,  1'b1, 1'b0, 0});
      vecs.push_back('{8'd20,  8'd13,  OP_MUL, 8'd4,   1'b1, 1'b0, 8});
      vecs.push_back('{8'd0,   8'd99,  OP_MUL, 8'd0,   1'b0, 1'b1, 8});
      vecs.push_back('{8'd255, 8'd255, OP_MUL, 8'd1,   1'b1, 1'b0, 8});
      vecs.push_back('{8'd6,   8'd7,   OP_MUL, 8'd42,  1'b0, 1'b0, 8});
`ifdef ALU_DIV_EN
      vecs.push_back('{8'd200, 8'd7,   OP_D6,  8'd28,  1'b0, 1'b0, 8});
      vecs.push_back('{8'd5,   8'd0,   OP_D6,  8'd255, 1'b1, 1'b0, 0});
      vecs.push_back('{8'd3,   8'd9,   OP_D6,  8'd0,   1'b0, 1'b1, 8});
`else
      vecs.push_back('{8'd3,   8'd9,   OP_D6,  8'd1,   1'b0, 1'b0, 0});
      vecs.push_back('{8'd9,   8'd3,   OP_D6,  8'd0,   1'b0, 1'b1, 0});
`endif

      foreach (vecs[i]) begin
         run_op(vecs[i].a, vecs[i].b, vecs[i].op, lat, rdy_seen);
         chk($sformatf("v%0d_lat", i),      lat,           vecs[i].lat);
         chk($sformatf("v%0d_valid", i),    bus.out_valid, 1);
         chk($sformatf("v%0d_result", i),   bus.result,    vecs[i].r);
         chk($sformatf("v%0d_carry", i),    bus.carry,     vecs[i].c);
         chk($sformatf("v%0d_zero", i),     bus.zero,      vecs[i].z);
         chk($sformatf("v%0d_busy_rdy", i), rdy_seen,      0);
      end

      // Back-to-back single-cycle ops with out_ready held high.
      bus.a = 8'd1; bus.b = 8'd1; bus.op = OP_ADD; bus.in_valid = 1'b1;
      #1;
      chk("tp_in_ready", bus.in_ready, 1);
      step();
      chk("tp_r0", bus.result, 2);
      bus.a = 8'd1; bus.b = 8'd2; bus.op = OP_OR;
      step();
      chk("tp_r1", bus.result, 3);
      chk("tp_v1", bus.out_valid, 1);
      bus.a = 8'd5; bus.b = 8'd5; bus.op = OP_XOR;
      step();
      chk("tp_r2", bus.result, 0);
      chk("tp_z2", bus.zero, 1);
      bus.in_valid = 1'b0;
      step();
      chk("tp_idle", bus.out_valid, 0);

      // Backpressure: result held while the consumer stalls.
      bus.out_ready = 1'b0;
      run_op(8'd200, 8'd100, OP_ADD, lat, rdy_seen);
      chk("bp_lat", lat, 0);
      for (int k = 0; k < 5; k++) begin
         step();
         chk($sformatf("bp%0d_valid", k),  bus.out_valid, 1);
         chk($sformatf("bp%0d_result", k), bus.result,    44);
         chk($sformatf("bp%0d_carry", k),  bus.carry,     1);
         chk($sformatf("bp%0d_ready", k),  bus.in_ready,  0);
      end
      bus.out_ready = 1'b1;
      bus.a = 8'd7; bus.b = 8'd3; bus.op = OP_SUB; bus.in_valid = 1'b1;
      #1;
      chk("bp_same_cycle_ready", bus.in_ready, 1);
      step();
      bus.in_valid = 1'b0;
      chk("bp_next_valid",  bus.out_valid, 1);
      chk("bp_next_result", bus.result,    4);
      chk("bp_next_carry",  bus.carry,     0);
      step();
      chk("bp_drain", bus.out_valid, 0);

      // Reset in the middle of a multiply.
      bus.a = 8'd20; bus.b = 8'd13; bus.op = OP_MUL; bus.in_valid = 1'b1;
      step();
      bus.in_valid = 1'b0;
      step();
      step();
      step();
      chk("mr_busy_valid", bus.out_valid, 0);
      chk("mr_busy_ready", bus.in_ready,  0);
      #2 rst_n = 1'b0;
      #1;
      chk("mr_rst_valid",  bus.out_valid, 0);
      chk("mr_rst_ready",  bus.in_ready,  1);
      chk("mr_rst_result", bus.result,    0);
      chk("mr_rst_carry",  bus.carry,     0);
      #3 rst_n = 1'b1;
      seen = 1'b0;
      for (int k = 0; k < 12; k++) begin
         step();
         seen = seen | bus.out_valid;
      end
      chk("mr_no_stale", seen, 0);
      chk("mr_idle_ready", bus.in_ready, 1);

      // Block still works after reset.
      run_op(8'd10, 8'd3, OP_MUL, lat, rdy_seen);
      chk("post_lat",    lat,        8);
      chk("post_result", bus.result, 30);
      chk("post_carry",  bus.carry,  0);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
